// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/status bundle for the register scoreboard.
// Handshake: decode holds issue_valid and its fields steady while stall is
// high; an issue counts as taken on the rising edge where issue_valid=1 and
// stall=0. RegWrite/WRegAdd is a plain one-cycle strobe with no back-pressure.
interface reg_scoreboard_if #(
    parameter int TOT_W = 3
);
    logic             issue_valid;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic             uses_rs;
    logic             uses_rt;
    logic [4:0]       dst_addr;
    logic             dst_we;
    logic             RegWrite;
    logic [4:0]       WRegAdd;
    logic             stall;
    logic [31:0]      busy_mask;
    logic [TOT_W-1:0] inflight;
    logic             err_underflow;

    // Decode / writeback side.
    modport master (
        output issue_valid, rs_addr, rt_addr, uses_rs, uses_rt,
        output dst_addr, dst_we, RegWrite, WRegAdd,
        input  stall, busy_mask, inflight, err_underflow
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, rs_addr, rt_addr, uses_rs, uses_rt,
        input  dst_addr, dst_we, RegWrite, WRegAdd,
        output stall, busy_mask, inflight, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts writes in flight per GPR between decode issue
// and writeback, and stalls decode on read-after-write hazards or when a
// destination counter or the total in-flight budget is full.
module reg_scoreboard #(
    parameter int CNT_W     = 2,
    parameter int MAX_TOTAL = 4,
    parameter int TOT_W     = 3,
    parameter bit WB_BYPASS = 1'b0
) (
    input logic             clk,
    input logic             reset,
    reg_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(MAX_TOTAL);
    localparam logic [TOT_W-1:0] TOT_ONE = TOT_W'(1);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [TOT_W-1:0] inflight_q;
    logic [TOT_W-1:0] inflight_d;
    logic             err_q;
    logic             err_d;

    logic [CNT_W-1:0] rs_cnt;
    logic [CNT_W-1:0] rt_cnt;
    logic [CNT_W-1:0] dst_cnt;
    logic [CNT_W-1:0] wb_cnt;

    logic rel_req;     // writeback strobe to a tracked register
    logic rel_ok;      // strobe that really retires a pending write
    logic rs_hit;
    logic rt_hit;
    logic dst_valid;
    logic dst_full;
    logic tot_full;
    logic stall_c;
    logic accept;
    logic [31:0] busy_c;

    assign rs_cnt  = cnt_q[sb.rs_addr];
    assign rt_cnt  = cnt_q[sb.rt_addr];
    assign dst_cnt = cnt_q[sb.dst_addr];
    assign wb_cnt  = cnt_q[sb.WRegAdd];

    assign rel_req = sb.RegWrite && (sb.WRegAdd != 5'd0);
    assign rel_ok  = rel_req && (wb_cnt != '0);

    // Source hazard detection; with bypass, a last pending write retiring
    // this cycle no longer blocks its readers.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        if (sb.uses_rs && (sb.rs_addr != 5'd0) && (rs_cnt != '0)) begin
            rs_hit = 1'b1;
            if (WB_BYPASS && rel_req && (sb.WRegAdd == sb.rs_addr) && (rs_cnt == CNT_ONE)) begin
                rs_hit = 1'b0;
            end
        end
        if (sb.uses_rt && (sb.rt_addr != 5'd0) && (rt_cnt != '0)) begin
            rt_hit = 1'b1;
            if (WB_BYPASS && rel_req && (sb.WRegAdd == sb.rt_addr) && (rt_cnt == CNT_ONE)) begin
                rt_hit = 1'b0;
            end
        end
    end

    // Capacity checks and the resulting stall / accept decision.
    always_comb begin
        dst_valid = sb.dst_we && (sb.dst_addr != 5'd0);
        dst_full  = dst_valid && (dst_cnt == CNT_MAX);
        // A retiring write frees one slot of the global budget this cycle.
        tot_full  = dst_valid && (inflight_q == TOT_MAX) && !rel_ok;
        stall_c   = sb.issue_valid && (rs_hit || rt_hit || dst_full || tot_full);
        accept    = sb.issue_valid && !stall_c && dst_valid;
    end

    // Per-register counter next state; an accept and a retire on the same
    // register cancel out.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && (sb.dst_addr == 5'(i)) && !(rel_ok && (sb.WRegAdd == 5'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (rel_ok && (sb.WRegAdd == 5'(i)) && !(accept && (sb.dst_addr == 5'(i)))) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
        // $0 is hardwired and never tracked.
        cnt_d[0] = '0;
    end

    // Total in-flight count and sticky underflow flag next state.
    always_comb begin
        inflight_d = inflight_q;
        if (accept && !rel_ok) begin
            inflight_d = inflight_q + TOT_ONE;
        end else if (rel_ok && !accept) begin
            inflight_d = inflight_q - TOT_ONE;
        end
        err_d = err_q || (rel_req && (wb_cnt == '0));
    end

    // State registers; reset discards every pending write immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Busy view derived from the registered counters.
    always_comb begin
        busy_c = '0;
        for (int i = 1; i < 32; i++) begin
            busy_c[i] = (cnt_q[i] != '0);
        end
    end

    assign sb.stall         = stall_c;
    assign sb.busy_mask     = busy_c;
    assign sb.inflight      = inflight_q;
    assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: one instance without and one with writeback
// bypass, fed identical inputs, each against a queue-of-pending-writes model.
module tb_reg_scoreboard;

    localparam int MAX_CNT = 3;
    localparam int MAX_TOT = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.TOT_W(3)) sb_a ();
    reg_scoreboard_if #(.TOT_W(3)) sb_b ();

    assign sb_b.issue_valid = sb_a.issue_valid;
    assign sb_b.rs_addr     = sb_a.rs_addr;
    assign sb_b.rt_addr     = sb_a.rt_addr;
    assign sb_b.uses_rs     = sb_a.uses_rs;
    assign sb_b.uses_rt     = sb_a.uses_rt;
    assign sb_b.dst_addr    = sb_a.dst_addr;
    assign sb_b.dst_we      = sb_a.dst_we;
    assign sb_b.RegWrite    = sb_a.RegWrite;
    assign sb_b.WRegAdd     = sb_a.WRegAdd;

    reg_scoreboard #(.CNT_W(2), .MAX_TOTAL(4), .TOT_W(3), .WB_BYPASS(1'b0)) dut_a (
        .clk(clk), .reset(reset), .sb(sb_a)
    );
    reg_scoreboard #(.CNT_W(2), .MAX_TOTAL(4), .TOT_W(3), .WB_BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .sb(sb_b)
    );

    logic        obs_stall [2];
    logic [31:0] obs_busy  [2];
    logic [2:0]  obs_inf   [2];
    logic        obs_err   [2];
    assign obs_stall[0] = sb_a.stall;
    assign obs_stall[1] = sb_b.stall;
    assign obs_busy[0]  = sb_a.busy_mask;
    assign obs_busy[1]  = sb_b.busy_mask;
    assign obs_inf[0]   = sb_a.inflight;
    assign obs_inf[1]   = sb_b.inflight;
    assign obs_err[0]   = sb_a.err_underflow;
    assign obs_err[1]   = sb_b.err_underflow;

    // Model: each pending write is one queue entry holding its destination.
    logic [4:0] exp_q0[$];
    logic [4:0] exp_q1[$];
    logic       m_err [2];

    function automatic int m_cnt(int k, logic [4:0] r);
        int n = 0;
        if (k == 0) begin
            foreach (exp_q0[i]) if (exp_q0[i] == r) n++;
        end else begin
            foreach (exp_q1[i]) if (exp_q1[i] == r) n++;
        end
        return n;
    endfunction

    function automatic int m_total(int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [31:0] m_busy(int k);
        logic [31:0] m = '0;
        if (k == 0) begin
            foreach (exp_q0[i]) m[exp_q0[i]] = 1'b1;
        end else begin
            foreach (exp_q1[i]) m[exp_q1[i]] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic m_src_busy(int k, logic used, logic [4:0] a);
        int  c;
        logic wb = sb_a.RegWrite && (sb_a.WRegAdd != 5'd0);
        if (!used || a == 5'd0) return 1'b0;
        c = m_cnt(k, a);
        if (c == 0) return 1'b0;
        if (k == 1 && wb && sb_a.WRegAdd == a && c == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_stall(int k);
        logic wb     = sb_a.RegWrite && (sb_a.WRegAdd != 5'd0);
        logic dst_ok = sb_a.dst_we && (sb_a.dst_addr != 5'd0);
        logic full_d = dst_ok && (m_cnt(k, sb_a.dst_addr) == MAX_CNT);
        logic full_t = dst_ok && (m_total(k) == MAX_TOT) && !(wb && m_cnt(k, sb_a.WRegAdd) > 0);
        return sb_a.issue_valid && (m_src_busy(k, sb_a.uses_rs, sb_a.rs_addr) ||
                                    m_src_busy(k, sb_a.uses_rt, sb_a.rt_addr) ||
                                    full_d || full_t);
    endfunction

    function automatic void m_retire(int k, logic [4:0] r);
        if (k == 0) begin
            for (int i = 0; i < exp_q0.size(); i++) if (exp_q0[i] == r) begin exp_q0.delete(i); break; end
        end else begin
            for (int i = 0; i < exp_q1.size(); i++) if (exp_q1[i] == r) begin exp_q1.delete(i); break; end
        end
    endfunction

    function automatic void m_clear();
        exp_q0.delete();
        exp_q1.delete();
        m_err[0] = 1'b0;
        m_err[1] = 1'b0;
    endfunction

    // Drivers
    task automatic drive(logic iv, logic [4:0] dst, logic dwe, logic urs, logic [4:0] rs,
                         logic urt, logic [4:0] rt, logic rw, logic [4:0] wa);
        sb_a.issue_valid = iv;
        sb_a.dst_addr    = dst;
        sb_a.dst_we      = dwe;
        sb_a.uses_rs     = urs;
        sb_a.rs_addr     = rs;
        sb_a.uses_rt     = urt;
        sb_a.rt_addr     = rt;
        sb_a.RegWrite    = rw;
        sb_a.WRegAdd     = wa;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    // Called between edges with inputs stable: update the model, cross the edge.
    task automatic advance();
        logic       acc [2];
        logic       had [2];
        logic       wb;
        logic [4:0] wa;
        logic [4:0] dst;
        wb  = sb_a.RegWrite && (sb_a.WRegAdd != 5'd0);
        wa  = sb_a.WRegAdd;
        dst = sb_a.dst_addr;
        for (int k = 0; k < 2; k++) begin
            acc[k] = sb_a.issue_valid && !m_stall(k) && sb_a.dst_we && (dst != 5'd0);
            had[k] = m_cnt(k, wa) > 0;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (wb) begin
                if (had[k]) m_retire(k, wa);
                else m_err[k] = 1'b1;
            end
            if (acc[k]) begin
                if (k == 0) exp_q0.push_back(dst);
                else exp_q1.push_back(dst);
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b0;
        m_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        m_clear();
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_busy[k] !== 32'h0) begin failures++; $display("FAIL reset_busy[%0d]: got %h want %h", k, obs_busy[k], 32'h0); end
            checks++; if (obs_inf[k] !== 3'd0) begin failures++; $display("FAIL reset_inflight[%0d]: got %0d want 0", k, obs_inf[k]); end
            checks++; if (obs_err[k] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d]: got %b want 0", k, obs_err[k]); end
            checks++; if (obs_stall[k] !== 1'b0) begin failures++; $display("FAIL reset_stall[%0d]: got %b want 0", k, obs_stall[k]); end
        end
        apply_reset();
    endtask

    task automatic test_src_stall();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (obs_stall[0] !== 1'b0) begin failures++; $display("FAIL src_issue5: got %b want 0", obs_stall[0]); end
        advance();
        // No valid issue: never a stall even though r5 is pending.
        drive(1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (obs_stall[0] !== 1'b0) begin failures++; $display("FAIL src_novalid: got %b want 0", obs_stall[0]); end
        advance();
        drive(1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_stall[k] !== 1'b1) begin failures++; $display("FAIL src_raw_stall[%0d]: got %b want 1", k, obs_stall[k]); end
            checks++; if (obs_busy[k] !== 32'h20) begin failures++; $display("FAIL src_busy[%0d]: got %h want %h", k, obs_busy[k], 32'h20); end
        end
        advance();
        // Same read, writeback to r5 now: only the bypass build frees it this cycle.
        drive(1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        @(negedge clk);
        checks++; if (obs_stall[0] !== 1'b1) begin failures++; $display("FAIL src_wb_nobyp: got %b want 1", obs_stall[0]); end
        checks++; if (obs_stall[1] !== 1'b0) begin failures++; $display("FAIL src_wb_byp: got %b want 0", obs_stall[1]); end
        advance();
        drive(1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_stall[k] !== 1'b0) begin failures++; $display("FAIL src_after_wb[%0d]: got %b want 0", k, obs_stall[k]); end
            checks++; if (obs_inf[k] !== 3'd0) begin failures++; $display("FAIL src_inflight[%0d]: got %0d want 0", k, obs_inf[k]); end
        end
        advance();
        idle();
    endtask

    task automatic test_reg_zero();
        drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        advance();
        drive(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        @(negedge clk);
        checks++; if (obs_stall[0] !== 1'b0) begin failures++; $display("FAIL zero_src_stall: got %b want 0", obs_stall[0]); end
        advance();
        idle();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_inf[k] !== 3'd0) begin failures++; $display("FAIL zero_inflight[%0d]: got %0d want 0", k, obs_inf[k]); end
            checks++; if (obs_busy[k] !== 32'h0) begin failures++; $display("FAIL zero_busy[%0d]: got %h want 0", k, obs_busy[k]); end
            checks++; if (obs_err[k] !== 1'b0) begin failures++; $display("FAIL zero_wb_err[%0d]: got %b want 0", k, obs_err[k]); end
        end
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            @(negedge clk);
            checks++; if (obs_stall[0] !== 1'b0) begin failures++; $display("FAIL sat_fill%0d: got %b want 0", i, obs_stall[0]); end
            advance();
        end
        drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (obs_stall[0] !== 1'b1) begin failures++; $display("FAIL sat_fourth: got %b want 1", obs_stall[0]); end
        checks++; if (obs_inf[0] !== 3'd3) begin failures++; $display("FAIL sat_inflight: got %0d want 3", obs_inf[0]); end
        advance();
        idle();
        sb_a.RegWrite = 1'b1;
        sb_a.WRegAdd  = 5'd7;
        @(negedge clk);
        advance();
        drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (obs_stall[0] !== 1'b0) begin failures++; $display("FAIL sat_accept: got %b want 0", obs_stall[0]); end
        advance();
        @(negedge clk);
        checks++; if (obs_stall[0] !== 1'b1) begin failures++; $display("FAIL sat_back_to_3: got %b want 1", obs_stall[0]); end
        checks++; if (obs_busy[0] !== 32'h80) begin failures++; $display("FAIL sat_busy: got %h want %h", obs_busy[0], 32'h80); end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
            @(negedge clk);
            advance();
        end
        idle();
        checks++; if (obs_inf[0] !== 3'd0) begin failures++; $display("FAIL sat_drain: got %0d want 0", obs_inf[0]); end
    endtask

    task automatic test_total_cap();
        for (int r = 1; r <= 4; r++) begin
            drive(1'b1, 5'(r), 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            @(negedge clk);
            advance();
        end
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++; if (obs_stall[0] !== 1'b1) begin failures++; $display("FAIL cap_full: got %b want 1", obs_stall[0]); end
        checks++; if (obs_inf[0] !== 3'd4) begin failures++; $display("FAIL cap_inflight4: got %0d want 4", obs_inf[0]); end
        advance();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1);
        @(negedge clk);
        checks++; if (obs_stall[0] !== 1'b0) begin failures++; $display("FAIL cap_wb_frees: got %b want 0", obs_stall[0]); end
        advance();
        idle();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_inf[k] !== 3'd4) begin failures++; $display("FAIL cap_swap_inflight[%0d]: got %0d want 4", k, obs_inf[k]); end
            checks++; if (obs_busy[k] !== 32'h21C) begin failures++; $display("FAIL cap_swap_busy[%0d]: got %h want %h", k, obs_busy[k], 32'h21C); end
        end
        for (int i = 0; i < 4; i++) begin
            logic [4:0] drain_seq [4];
            drain_seq = '{5'd2, 5'd3, 5'd4, 5'd9};
            drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, drain_seq[i]);
            @(negedge clk);
            advance();
        end
        idle();
        checks++; if (obs_inf[0] !== 3'd0) begin failures++; $display("FAIL cap_drain: got %0d want 0", obs_inf[0]); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12);
        @(negedge clk);
        checks++; if (obs_err[0] !== 1'b0) begin failures++; $display("FAIL uf_before: got %b want 0", obs_err[0]); end
        advance();
        idle();
        repeat (3) begin
            @(negedge clk);
            advance();
        end
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_err[k] !== 1'b1) begin failures++; $display("FAIL uf_sticky[%0d]: got %b want 1", k, obs_err[k]); end
            checks++; if (obs_inf[k] !== 3'd0) begin failures++; $display("FAIL uf_inflight[%0d]: got %0d want 0", k, obs_inf[k]); end
        end
    endtask

    task automatic test_async_reset();
        for (int r = 1; r <= 3; r++) begin
            drive(1'b1, 5'(r), 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            @(negedge clk);
            advance();
        end
        idle();
        checks++; if (obs_inf[0] !== 3'd3) begin failures++; $display("FAIL ar_pre_inflight: got %0d want 3", obs_inf[0]); end
        #2;
        reset = 1'b0;
        m_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_busy[k] !== 32'h0) begin failures++; $display("FAIL ar_busy[%0d]: got %h want 0", k, obs_busy[k]); end
            checks++; if (obs_inf[k] !== 3'd0) begin failures++; $display("FAIL ar_inflight[%0d]: got %0d want 0", k, obs_inf[k]); end
            checks++; if (obs_err[k] !== 1'b0) begin failures++; $display("FAIL ar_err[%0d]: got %b want 0", k, obs_err[k]); end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 7));
            if (exp_q0.size() > 0 && $urandom_range(0, 3) != 0) begin
                wa = exp_q0[$urandom_range(0, exp_q0.size() - 1)];
            end
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) == 0), wa);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++; if (obs_stall[k] !== m_stall(k)) begin failures++; $display("FAIL rnd_stall[%0d] cyc %0d: got %b want %b", k, n, obs_stall[k], m_stall(k)); end
                checks++; if (obs_busy[k] !== m_busy(k)) begin failures++; $display("FAIL rnd_busy[%0d] cyc %0d: got %h want %h", k, n, obs_busy[k], m_busy(k)); end
                checks++; if (obs_inf[k] !== 3'(m_total(k))) begin failures++; $display("FAIL rnd_inflight[%0d] cyc %0d: got %0d want %0d", k, n, obs_inf[k], m_total(k)); end
                checks++; if (obs_err[k] !== m_err[k]) begin failures++; $display("FAIL rnd_err[%0d] cyc %0d: got %b want %b", k, n, obs_err[k], m_err[k]); end
            end
            advance();
        end
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        m_clear();
        test_reset();
        test_src_stall();
        test_reg_zero();
        test_count_sat();
        test_total_cap();
        test_underflow();
        test_async_reset();
        apply_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
